mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data Memory_System port between two requesters.
  - Port C: the multi-cycle MIPS core.
  - Port L: the program loader / debug DMA.
- One registered FSM grants exactly one single-word access per grant cycle.
- Policy is round-robin, plus a loader-exclusive boot mode.
- Sits between the core's address mux / B register and the memory; the core stalls its control FSM on cpu_gnt.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 57 +++++
 tb/tb_mem_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core, loader and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;
  logic                  ldr_req;
  logic                  ldr_we;
  logic [DATA_WIDTH-1:0] ldr_addr;
  logic [DATA_WIDTH-1:0] ldr_wdata;
  logic                  ldr_gnt;
  logic [DATA_WIDTH-1:0] ldr_rdata;
  logic                  ldr_rvalid;
  logic                  ldr_excl;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_excl,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output ldr_gnt, ldr_rdata, ldr_rvalid,
    output mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_excl,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  ldr_gnt, ldr_rdata, ldr_rvalid,
    input  mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between core and loader,
// one single-word access per grant cycle, with a loader-exclusive boot mode.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT_C, GNT_L} state_t;
  state_t                r_state, w_next;
  logic                  r_last_l;
  logic                  r_cpu_rvalid, r_ldr_rvalid;
  logic [DATA_WIDTH-1:0] r_cpu_rdata, r_ldr_rdata;
  logic                  w_excl, w_gc, w_gl, w_crd, w_lrd;
  assign w_excl = bus.ldr_excl & BOOT_HOLD;
  assign w_gc   = r_state == GNT_C;
  assign w_gl   = r_state == GNT_L;
  assign w_crd  = w_gc & ~bus.cpu_we;
  assign w_lrd  = w_gl & ~bus.ldr_we;
  // r_last_l resets high so the core wins the first tie
  always_comb begin
    w_next = IDLE;
    w_next = (bus.ldr_req && (w_excl || !bus.cpu_req || !r_last_l)) ? GNT_L :
             (bus.cpu_req && !w_excl) ? GNT_C : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_l     <= 1'b1;
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
    end else begin
      r_state      <= w_next;
      r_cpu_rvalid <= w_crd;
      r_ldr_rvalid <= w_lrd;
      if (w_next != IDLE) r_last_l <= (w_next == GNT_L);
      if (w_crd) r_cpu_rdata <= bus.mem_rdata;
      if (w_lrd) r_ldr_rdata <= bus.mem_rdata;
    end
  end
  always_comb begin
    bus.cpu_gnt    = w_gc;
    bus.ldr_gnt    = w_gl;
    bus.busy       = w_gc | w_gl;
    bus.cpu_rvalid = r_cpu_rvalid;
    bus.ldr_rvalid = r_ldr_rvalid;
    bus.cpu_rdata  = r_cpu_rdata;
    bus.ldr_rdata  = r_ldr_rdata;
    bus.mem_we     = w_gc ? bus.cpu_we    : w_gl ? bus.ldr_we    : 1'b0;
    bus.mem_addr   = w_gc ? bus.cpu_addr  : w_gl ? bus.ldr_addr  : '0;
    bus.mem_wdata  = w_gc ? bus.cpu_wdata : w_gl ? bus.ldr_wdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, data path, exclusive mode and reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_excl = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0, mem_rd = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.DATA_WIDTH(32)) b0 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32)) b1 ();
  assign b0.cpu_req = cpu_req;     assign b1.cpu_req = cpu_req;
  assign b0.cpu_we = cpu_we;       assign b1.cpu_we = cpu_we;
  assign b0.cpu_addr = cpu_addr;   assign b1.cpu_addr = cpu_addr;
  assign b0.cpu_wdata = cpu_wdata; assign b1.cpu_wdata = cpu_wdata;
  assign b0.ldr_req = ldr_req;     assign b1.ldr_req = ldr_req;
  assign b0.ldr_we = ldr_we;       assign b1.ldr_we = ldr_we;
  assign b0.ldr_addr = ldr_addr;   assign b1.ldr_addr = ldr_addr;
  assign b0.ldr_wdata = ldr_wdata; assign b1.ldr_wdata = ldr_wdata;
  assign b0.ldr_excl = ldr_excl;   assign b1.ldr_excl = ldr_excl;
  assign b0.mem_rdata = mem_rd;    assign b1.mem_rdata = mem_rd;
  mem_port_arbiter #(.DATA_WIDTH(32), .BOOT_HOLD(1'b1)) dut (.clk(clk), .reset(reset), .bus(b0));
  mem_port_arbiter #(.DATA_WIDTH(32), .BOOT_HOLD(1'b0)) dut_nb (.clk(clk), .reset(reset), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_cgnt", 32'(b0.cpu_gnt), 32'd0);
    chk("rst_mwe", 32'(b0.mem_we), 32'd0);
    chk("rst_maddr", b0.mem_addr, 32'h0);
    chk("rst_crv", 32'(b0.cpu_rvalid), 32'd0);
    chk("rst_crd", b0.cpu_rdata, 32'h0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0040_0000; mem_rd = 32'h2008_0005;
    tick;
    chk("rd_cgnt", 32'(b0.cpu_gnt), 32'd1);
    chk("rd_busy1", 32'(b0.busy), 32'd1);
    chk("rd_maddr", b0.mem_addr, 32'h0040_0000);
    chk("rd_mwe", 32'(b0.mem_we), 32'd0);
    chk("rd_crv1", 32'(b0.cpu_rvalid), 32'd0);
    cpu_req = 0;
    tick;
    chk("rd_crv2", 32'(b0.cpu_rvalid), 32'd1);
    chk("rd_crd", b0.cpu_rdata, 32'h2008_0005);
    chk("rd_busy2", 32'(b0.busy), 32'd0);
    chk("rd_cgnt2", 32'(b0.cpu_gnt), 32'd0);
    mem_rd = 32'h1234_5678;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h1001_0000; ldr_wdata = 32'hDEAD_BEEF;
    tick;
    chk("rd_crv3", 32'(b0.cpu_rvalid), 32'd0);
    chk("wr_lgnt", 32'(b0.ldr_gnt), 32'd1);
    chk("wr_mwe", 32'(b0.mem_we), 32'd1);
    chk("wr_maddr", b0.mem_addr, 32'h1001_0000);
    chk("wr_mwdata", b0.mem_wdata, 32'hDEAD_BEEF);
    ldr_req = 0;
    tick;
    chk("wr_mwe_off", 32'(b0.mem_we), 32'd0);
    chk("wr_maddr_off", b0.mem_addr, 32'h0);
    chk("wr_lrv", 32'(b0.ldr_rvalid), 32'd0);
    chk("wr_crd_keep", b0.cpu_rdata, 32'h2008_0005);
    chk("wr_lrd_keep", b0.ldr_rdata, 32'h0);
    reset = 1;
    tick;
    reset = 0;
    cpu_req = 1; cpu_we = 0; ldr_req = 1; ldr_we = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("rr_c%0d", i), 32'(b0.cpu_gnt), 32'(i % 2 == 0));
      chk($sformatf("rr_l%0d", i), 32'(b0.ldr_gnt), 32'(i % 2 == 1));
      chk($sformatf("rr_nb%0d", i), 32'(b1.cpu_gnt), 32'(i % 2 == 0));
    end
    cpu_req = 0; ldr_req = 0;
    tick;
    chk("rr_idle", 32'(b0.busy), 32'd0);
    chk("rr_lrv", 32'(b0.ldr_rvalid), 32'd1);
    chk("rr_lrd", b0.ldr_rdata, 32'h1234_5678);
    ldr_excl = 1; cpu_req = 1; ldr_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("ex_l%0d", i), 32'(b0.ldr_gnt), 32'd1);
      chk($sformatf("ex_c%0d", i), 32'(b0.cpu_gnt), 32'd0);
      chk($sformatf("nb_c%0d", i), 32'(b1.cpu_gnt), 32'(i % 2 == 0));
    end
    ldr_excl = 0;
    tick;
    chk("ex_off_c", 32'(b0.cpu_gnt), 32'd1);
    chk("nb_off_l", 32'(b1.ldr_gnt), 32'd1);
    cpu_req = 0; ldr_req = 0;
    tick;
    tick;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'h0000_0055;
    tick;
    chk("ar_mwe", 32'(b0.mem_we), 32'd1);
    chk("ar_cgnt", 32'(b0.cpu_gnt), 32'd1);
    ldr_req = 1; ldr_we = 0;
    #2 reset = 1;
    #1;
    chk("ar_mwe0", 32'(b0.mem_we), 32'd0);
    chk("ar_cgnt0", 32'(b0.cpu_gnt), 32'd0);
    chk("ar_busy0", 32'(b0.busy), 32'd0);
    chk("ar_maddr0", b0.mem_addr, 32'h0);
    chk("ar_crd0", b0.cpu_rdata, 32'h0);
    tick;
    chk("ar_hold", 32'(b0.busy), 32'd0);
    reset = 0;
    tick;
    chk("ar_first_c", 32'(b0.cpu_gnt), 32'd1);
    chk("ar_first_l", 32'(b0.ldr_gnt), 32'd0);
    cpu_req = 0; ldr_req = 0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
